mem_port_arbiter: RTL and testbench

- Shares one single-ported synchronous SRAM between two requesters: instruction fetch (read-only) and the MEM stage (byte-select load/store).
- Sits between the pipeline and the SRAM.
- Sequences each access with a small FSM and a configurable wait-state counter.
- Returns read data with a one-cycle ready pulse and raises a pipeline stall request while any request is outstanding.

---
 rtl/mem_port_arbiter_if.sv | 53 +++++
 rtl/mem_port_arbiter.sv | 178 +++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 310 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if
//   Signal bundle for mem_port_arbiter. It groups the instruction-fetch port, the MEM-stage
//   data port, the pipeline stall request and the single-ported SRAM port.
//
//   Modports:
//     slave  - the arbiter side. It receives requests and sram_rdata, and drives ready/rdata,
//              stall_req and the sram_* control/data.
//     master - the surrounding environment (pipeline plus SRAM), with every direction reversed.
//
//   Parameters: ADDR_W (address width), DATA_W (data width; byte enables are DATA_W/8 wide).
interface mem_port_arbiter_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
);
    localparam int unsigned BE_W = DATA_W / 8;

    // Instruction fetch port (read-only)
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic [DATA_W-1:0] if_rdata;
    logic              if_ready;

    // MEM-stage data port
    logic              mem_ce;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [BE_W-1:0]   mem_sel;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ready;

    logic              stall_req;

    // SRAM port
    logic              sram_ce;
    logic              sram_we;
    logic [ADDR_W-1:0] sram_addr;
    logic [BE_W-1:0]   sram_be;
    logic [DATA_W-1:0] sram_wdata;
    logic [DATA_W-1:0] sram_rdata;

    modport slave (
        input  if_req, if_addr, mem_ce, mem_we, mem_addr, mem_sel, mem_wdata, sram_rdata,
        output if_rdata, if_ready, mem_rdata, mem_ready, stall_req,
               sram_ce, sram_we, sram_addr, sram_be, sram_wdata
    );

    modport master (
        output if_req, if_addr, mem_ce, mem_we, mem_addr, mem_sel, mem_wdata, sram_rdata,
        input  if_rdata, if_ready, mem_rdata, mem_ready, stall_req,
               sram_ce, sram_we, sram_addr, sram_be, sram_wdata
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one single-ported synchronous SRAM between instruction fetch (read-only) and the
//   MEM stage (byte-select load/store). Each access runs IDLE -> ACCESS (1 + WAIT_CYCLES
//   cycles) -> DONE. The owner gets a one-cycle ready pulse in DONE. stall_req is raised while
//   any request is pending and its ready has not yet pulsed.
//
//   Ports:
//     clk  - clock, rising edge
//     rst  - synchronous, active-high reset
//     bus  - mem_port_arbiter_if.slave: if_* fetch port, mem_* data port, stall_req, sram_*
//
//   Parameters: ADDR_W, DATA_W, WAIT_CYCLES (0..15 extra SRAM wait states per access).
//
//   Optional feature: define ROUND_ROBIN_EN to alternate grants when both requesters are
//   pending. Without it, MEM has fixed priority over IF.
module mem_port_arbiter #(
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned WAIT_CYCLES = 1
) (
    input  logic              clk,
    input  logic              rst,
    mem_port_arbiter_if.slave bus
);
    localparam int unsigned BE_W      = DATA_W / 8;
    localparam logic [3:0]  WAIT_INIT = 4'(WAIT_CYCLES);

    typedef enum logic [1:0] {StIdle, StAccess, StDone} state_e;

    state_e            state_q, state_d;
    logic              owner_q, owner_d;          // 0 = IF, 1 = MEM
    logic [3:0]        wait_cnt_q, wait_cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              we_q, we_d;
    logic [BE_W-1:0]   be_q, be_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              abort_q, abort_d;          // owner dropped its request during ACCESS
    logic              if_ready_q, if_ready_d;
    logic              mem_ready_q, mem_ready_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0] mem_rdata_q, mem_rdata_d;
    logic              grant_mem;
    logic              req_live;
    logic              access;
`ifdef ROUND_ROBIN_EN
    logic              last_owner_q, last_owner_d;
`endif

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        wait_cnt_d  = wait_cnt_q;
        addr_d      = addr_q;
        we_d        = we_q;
        be_d        = be_q;
        wdata_d     = wdata_q;
        abort_d     = abort_q;
        if_ready_d  = 1'b0;
        mem_ready_d = 1'b0;
        if_rdata_d  = if_rdata_q;
        mem_rdata_d = mem_rdata_q;
`ifdef ROUND_ROBIN_EN
        last_owner_d = last_owner_q;
        if (bus.mem_ce && bus.if_req) begin
            grant_mem = ~last_owner_q;
        end else begin
            grant_mem = bus.mem_ce;
        end
`else
        grant_mem = bus.mem_ce;
`endif
        req_live = owner_q ? bus.mem_ce : bus.if_req;

        unique case (state_q)
            StIdle: begin
                if (bus.mem_ce || bus.if_req) begin
                    owner_d    = grant_mem;
                    wait_cnt_d = WAIT_INIT;
                    abort_d    = 1'b0;
                    state_d    = StAccess;
`ifdef ROUND_ROBIN_EN
                    last_owner_d = grant_mem;
`endif
                    if (grant_mem) begin
                        addr_d  = bus.mem_addr;
                        we_d    = bus.mem_we;
                        be_d    = bus.mem_sel;
                        wdata_d = bus.mem_wdata;
                    end else begin
                        addr_d  = bus.if_addr;
                        we_d    = 1'b0;
                        be_d    = '1;
                        wdata_d = '0;
                    end
                end
            end
            StAccess: begin
                // A withdrawn request lets the SRAM cycle finish but suppresses ready,
                // even if the requester raises a new request before the access ends.
                if (!req_live) begin
                    abort_d = 1'b1;
                end
                if (wait_cnt_q != 4'd0) begin
                    wait_cnt_d = wait_cnt_q - 4'd1;
                end else begin
                    state_d = StDone;
                    // Ready is registered so it is high exactly during DONE.
                    if (req_live && !abort_q) begin
                        if (owner_q) begin
                            mem_ready_d = 1'b1;
                            mem_rdata_d = bus.sram_rdata;
                        end else begin
                            if_ready_d = 1'b1;
                            if_rdata_d = bus.sram_rdata;
                        end
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            owner_q     <= 1'b0;
            wait_cnt_q  <= 4'd0;
            addr_q      <= '0;
            we_q        <= 1'b0;
            be_q        <= '0;
            wdata_q     <= '0;
            abort_q     <= 1'b0;
            if_ready_q  <= 1'b0;
            mem_ready_q <= 1'b0;
            if_rdata_q  <= '0;
            mem_rdata_q <= '0;
`ifdef ROUND_ROBIN_EN
            last_owner_q <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            wait_cnt_q  <= wait_cnt_d;
            addr_q      <= addr_d;
            we_q        <= we_d;
            be_q        <= be_d;
            wdata_q     <= wdata_d;
            abort_q     <= abort_d;
            if_ready_q  <= if_ready_d;
            mem_ready_q <= mem_ready_d;
            if_rdata_q  <= if_rdata_d;
            mem_rdata_q <= mem_rdata_d;
`ifdef ROUND_ROBIN_EN
            last_owner_q <= last_owner_d;
`endif
        end
    end

    // SRAM controls come from the latched request and are zero outside ACCESS.
    assign access         = (state_q == StAccess);
    assign bus.sram_ce    = access;
    assign bus.sram_we    = access & we_q;
    assign bus.sram_addr  = access ? addr_q : '0;
    assign bus.sram_be    = access ? be_q : '0;
    assign bus.sram_wdata = access ? wdata_q : '0;

    assign bus.if_ready   = if_ready_q;
    assign bus.mem_ready  = mem_ready_q;
    assign bus.if_rdata   = if_rdata_q;
    assign bus.mem_rdata  = mem_rdata_q;

    assign bus.stall_req  = (bus.mem_ce | bus.if_req) & ~(mem_ready_q | if_ready_q);
endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;
    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned W  = 1;

    typedef struct packed {
        logic [31:0] data;
        logic        chk;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        sram_init;
    int unsigned cyc = 0;
    int          n_chk = 0;
    int          n_fail = 0;
    int          if_ready_cnt = 0;
    int          mem_ready_cnt = 0;
    bit          bus_chk_en = 1'b1;
    exp_t        if_exp[$];
    exp_t        mem_exp[$];
    logic [31:0] ref_mem [256];
    logic [31:0] sram_mem [256];
    logic        if_stall_at_ready, mem_stall_at_ready;
    int          lat_a, lat_b, lat_ri, lat_rm;

    mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .WAIT_CYCLES(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] init_word(input int i);
        if (i == 32'h40) return 32'hDEADBEEF;
        return {8'(i), 8'(i) ^ 8'h5A, ~8'(i), 8'(i * 7)};
    endfunction

    // SRAM stand-in: combinational read of the addressed word, byte-enabled write.
    assign bus.sram_rdata = sram_mem[bus.sram_addr[9:2]];
    always @(posedge clk) begin
        if (sram_init) begin
            for (int i = 0; i < 256; i++) sram_mem[i] <= init_word(i);
        end else if (bus.sram_ce && bus.sram_we) begin
            for (int b = 0; b < 4; b++)
                if (bus.sram_be[b]) sram_mem[bus.sram_addr[9:2]][8*b +: 8] <= bus.sram_wdata[8*b +: 8];
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: scoreboard pops on every ready pulse, plus stall and SRAM bus checks.
    exp_t        mon_e;
    int          run = 0;
    logic [31:0] r_addr, r_wdata, last_addr, last_wdata;
    logic [3:0]  r_be, last_be;
    logic        r_we, last_we;
    always begin
        @(posedge clk);
        #1;
        if (bus.if_ready) begin
            if_ready_cnt++;
            chk("if_ready_expected", 64'(if_exp.size() != 0), 64'd1);
            if (if_exp.size() != 0) begin
                mon_e = if_exp.pop_front();
                if (mon_e.chk) chk("if_rdata", 64'(bus.if_rdata), 64'(mon_e.data));
            end
        end
        if (bus.mem_ready) begin
            mem_ready_cnt++;
            chk("mem_ready_expected", 64'(mem_exp.size() != 0), 64'd1);
            if (mem_exp.size() != 0) begin
                mon_e = mem_exp.pop_front();
                if (mon_e.chk) chk("mem_rdata", 64'(bus.mem_rdata), 64'(mon_e.data));
            end
        end
        chk("stall_req", 64'(bus.stall_req),
            64'((bus.mem_ce | bus.if_req) & ~(bus.mem_ready | bus.if_ready)));
        if (bus.sram_ce) begin
            if (run == 0) begin
                r_addr = bus.sram_addr; r_we = bus.sram_we;
                r_be = bus.sram_be; r_wdata = bus.sram_wdata;
            end else begin
                chk("sram_addr_stable", 64'(bus.sram_addr), 64'(r_addr));
                chk("sram_be_stable", 64'(bus.sram_be), 64'(r_be));
                chk("sram_we_stable", 64'(bus.sram_we), 64'(r_we));
                chk("sram_wdata_stable", 64'(bus.sram_wdata), 64'(r_wdata));
            end
            run++;
        end else if (run != 0) begin
            if (bus_chk_en) chk("sram_ce_length", 64'(run), 64'(W + 1));
            last_addr = r_addr; last_we = r_we; last_be = r_be; last_wdata = r_wdata;
            run = 0;
        end
    end

    task automatic do_if(input logic [31:0] addr, output int lat);
        int unsigned start;
        @(posedge clk); #2;
        bus.if_req  = 1'b1;
        bus.if_addr = addr;
        if_exp.push_back(exp_t'{data: ref_mem[addr[9:2]], chk: 1'b1});
        start = cyc;
        lat = -1;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk); #2;
            if (bus.if_ready) begin
                lat = int'(cyc - start);
                if_stall_at_ready = bus.stall_req;
                break;
            end
        end
        chk("if_ready_within_bound", 64'(lat >= 0), 64'd1);
        bus.if_req = 1'b0;
    endtask

    task automatic do_mem(input logic we, input logic [31:0] addr, input logic [3:0] sel,
                          input logic [31:0] wdata, output int lat);
        int unsigned start;
        @(posedge clk); #2;
        bus.mem_ce = 1'b1; bus.mem_we = we; bus.mem_addr = addr;
        bus.mem_sel = sel; bus.mem_wdata = wdata;
        if (we) begin
            for (int b = 0; b < 4; b++)
                if (sel[b]) ref_mem[addr[9:2]][8*b +: 8] = wdata[8*b +: 8];
            mem_exp.push_back(exp_t'{data: 32'h0, chk: 1'b0});
        end else begin
            mem_exp.push_back(exp_t'{data: ref_mem[addr[9:2]], chk: 1'b1});
        end
        start = cyc;
        lat = -1;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk); #2;
            if (bus.mem_ready) begin
                lat = int'(cyc - start);
                mem_stall_at_ready = bus.stall_req;
                break;
            end
        end
        chk("mem_ready_within_bound", 64'(lat >= 0), 64'd1);
        bus.mem_ce = 1'b0;
    endtask

    // Hold a request for fewer cycles than the minimum latency, then drop it.
    task automatic withdraw_if(input logic [31:0] addr, input int hold);
        @(posedge clk); #2;
        bus.if_req = 1'b1; bus.if_addr = addr;
        repeat (hold) begin @(posedge clk); #2; end
        bus.if_req = 1'b0;
    endtask

    task automatic withdraw_load(input logic [31:0] addr, input int hold);
        @(posedge clk); #2;
        bus.mem_ce = 1'b1; bus.mem_we = 1'b0; bus.mem_addr = addr; bus.mem_sel = 4'hF;
        repeat (hold) begin @(posedge clk); #2; end
        bus.mem_ce = 1'b0;
    endtask

    initial begin
        int unsigned r1, r2, start;
        int          cnt0;
        for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);
        rst = 1'b1; sram_init = 1'b1;
        bus.if_req = 1'b0; bus.if_addr = '0;
        bus.mem_ce = 1'b0; bus.mem_we = 1'b0; bus.mem_addr = '0;
        bus.mem_sel = '0; bus.mem_wdata = '0;
        repeat (3) @(posedge clk);
        #2;
        chk("rst_sram_ce", 64'(bus.sram_ce), 64'd0);
        chk("rst_sram_we", 64'(bus.sram_we), 64'd0);
        chk("rst_sram_addr", 64'(bus.sram_addr), 64'd0);
        chk("rst_sram_be", 64'(bus.sram_be), 64'd0);
        chk("rst_if_ready", 64'(bus.if_ready), 64'd0);
        chk("rst_mem_ready", 64'(bus.mem_ready), 64'd0);
        chk("rst_if_rdata", 64'(bus.if_rdata), 64'd0);
        chk("rst_mem_rdata", 64'(bus.mem_rdata), 64'd0);
        chk("rst_stall_req", 64'(bus.stall_req), 64'd0);
        rst = 1'b0; sram_init = 1'b0;

        // IF-only read of 0x100
        do_if(32'h100, lat_a);
        chk("if_read_latency", 64'(lat_a), 64'(W + 2));
        chk("if_read_stall_at_ready", 64'(if_stall_at_ready), 64'd0);
        chk("if_read_rdata_held", 64'(bus.if_rdata), 64'hDEADBEEF);

        // Byte store to an unaligned address, then read the merged word back
        do_mem(1'b1, 32'h203, 4'b1000, 32'h5A5A5A5A, lat_a);
        chk("store_latency", 64'(lat_a), 64'(W + 2));
        chk("store_sram_we", 64'(last_we), 64'd1);
        chk("store_sram_be", 64'(last_be), 64'h8);
        chk("store_sram_addr", 64'(last_addr), 64'h203);
        chk("store_sram_wdata", 64'(last_wdata), 64'h5A5A5A5A);
        do_mem(1'b0, 32'h200, 4'hF, 32'h0, lat_a);

        // Store with no byte selected is a timed no-op
        do_mem(1'b1, 32'h204, 4'b0000, 32'hFFFFFFFF, lat_a);
        chk("nosel_latency", 64'(lat_a), 64'(W + 2));
        chk("nosel_sram_be", 64'(last_be), 64'h0);
        do_mem(1'b0, 32'h204, 4'hF, 32'h0, lat_a);

        // Contention: both raise together; last grant went to MEM
        fork
            do_mem(1'b0, 32'h300, 4'hF, 32'h0, lat_a);
            do_if(32'h044, lat_b);
        join
`ifdef ROUND_ROBIN_EN
        chk("contend_if_latency", 64'(lat_b), 64'(W + 2));
        chk("contend_mem_latency", 64'(lat_a), 64'(2 * W + 5));
`else
        chk("contend_mem_latency", 64'(lat_a), 64'(W + 2));
        chk("contend_if_latency", 64'(lat_b), 64'(2 * W + 5));
`endif

        // Back-to-back loads: one IDLE cycle between accesses
        do_mem(1'b0, 32'h210, 4'hF, 32'h0, lat_a);
        r1 = cyc;
        do_mem(1'b0, 32'h214, 4'hF, 32'h0, lat_a);
        r2 = cyc;
        chk("back_to_back_spacing", 64'(r2 - r1), 64'(W + 3));

        // Withdrawn store: SRAM write still lands, no ready pulse
        @(posedge clk); #2;
        cnt0 = mem_ready_cnt;
        bus.mem_ce = 1'b1; bus.mem_we = 1'b1; bus.mem_addr = 32'h280;
        bus.mem_sel = 4'hF; bus.mem_wdata = 32'h13579BDF;
        @(posedge clk); #2;
        bus.mem_ce = 1'b0;
        repeat (W + 4) @(posedge clk);
        #2;
        chk("withdrawn_no_ready", 64'(mem_ready_cnt), 64'(cnt0));
        ref_mem[8'hA0] = 32'h13579BDF;
        do_mem(1'b0, 32'h280, 4'hF, 32'h0, lat_a);

        // Reset during the second ACCESS cycle
        bus_chk_en = 1'b0;
        @(posedge clk); #2;
        cnt0 = mem_ready_cnt;
        bus.mem_ce = 1'b1; bus.mem_we = 1'b0; bus.mem_addr = 32'h240; bus.mem_sel = 4'hF;
        start = cyc;
        @(posedge clk); #2;
        @(posedge clk); #2;
        chk("pre_reset_in_access", 64'(bus.sram_ce), 64'd1);
        rst = 1'b1;
        bus.mem_ce = 1'b0;
        @(posedge clk); #2;
        chk("midrst_sram_ce", 64'(bus.sram_ce), 64'd0);
        chk("midrst_sram_we", 64'(bus.sram_we), 64'd0);
        chk("midrst_sram_addr", 64'(bus.sram_addr), 64'd0);
        chk("midrst_sram_be", 64'(bus.sram_be), 64'd0);
        chk("midrst_sram_wdata", 64'(bus.sram_wdata), 64'd0);
        chk("midrst_mem_ready", 64'(bus.mem_ready), 64'd0);
        chk("midrst_if_rdata", 64'(bus.if_rdata), 64'd0);
        chk("midrst_mem_rdata", 64'(bus.mem_rdata), 64'd0);
        chk("midrst_stall_req", 64'(bus.stall_req), 64'd0);
        rst = 1'b0;
        repeat (W + 5) @(posedge clk);
        #2;
        chk("midrst_no_ready", 64'(mem_ready_cnt), 64'(cnt0));
        chk("midrst_elapsed", 64'(cyc - start >= 3), 64'd1);
        bus_chk_en = 1'b1;

        // Randomized concurrent traffic from both requesters
        fork
            begin : if_traffic
                logic [31:0] a;
                for (int i = 0; i < 80; i++) begin
                    repeat ($urandom_range(0, 3)) @(posedge clk);
                    a = 32'($urandom_range(0, 127)) << 2;
                    if ($urandom_range(0, 7) == 0) withdraw_if(a, int'($urandom_range(1, W + 1)));
                    else do_if(a, lat_ri);
                end
            end
            begin : mem_traffic
                logic [31:0] a;
                int          k;
                for (int i = 0; i < 80; i++) begin
                    repeat ($urandom_range(0, 3)) @(posedge clk);
                    a = (32'($urandom_range(128, 255)) << 2) | 32'($urandom_range(0, 3));
                    k = int'($urandom_range(0, 7));
                    if (k == 0) withdraw_load(a, int'($urandom_range(1, W + 1)));
                    else if (k < 4) do_mem(1'b1, a, 4'($urandom_range(0, 15)), $urandom, lat_rm);
                    else do_mem(1'b0, a, 4'hF, 32'h0, lat_rm);
                end
            end
        join

        repeat (10) @(posedge clk);
        #2;
        chk("if_scoreboard_drained", 64'(if_exp.size()), 64'd0);
        chk("mem_scoreboard_drained", 64'(mem_exp.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end
endmodule
